// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: one result bit per cycle, MTHI/MTLO writes when idle.
// Signed operations run on magnitudes and apply sign correction when the result is written.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0]   cnt;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               dz_pend;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   mq;
    logic [WIDTH-1:0]   opnd;

    logic               a_neg, b_neg, div_by_zero_in;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] product, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    always_comb begin
        a_neg          = ~op[0] & op_a[WIDTH-1];
        b_neg          = ~op[0] & op_b[WIDTH-1];
        mag_a          = a_neg ? (~op_a + 1'b1) : op_a;
        mag_b          = b_neg ? (~op_b + 1'b1) : op_b;
        div_by_zero_in = op[1] & (op_b == '0);
    end

    // acc holds the running high half (multiply) or partial remainder (divide);
    // mq shifts out multiplier/dividend bits while product/quotient bits shift in.
    always_comb begin
        mul_sum   = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : '0);
        div_shift = {acc, mq[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        product   = {acc, mq};
        prod_fix  = neg_q ? (~product + 1'b1) : product;
        quot_fix  = neg_q ? (~mq + 1'b1) : mq;
        rem_fix   = neg_r ? (~acc + 1'b1) : acc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = div_by_zero_in ? FINISH : CALC;
            CALC:    if (cnt == CNT_W'(WIDTH - 1)) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz_pend  <= 1'b0;
            acc      <= '0;
            mq       <= '0;
            opnd     <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        is_div  <= op[1];
                        neg_q   <= a_neg ^ b_neg;
                        neg_r   <= op[1] & a_neg;
                        dz_pend <= div_by_zero_in;
                        acc     <= '0;
                        mq      <= mag_a;
                        opnd    <= mag_b;
                        cnt     <= '0;
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (is_div) begin
                        if (!div_diff[WIDTH]) begin
                            acc <= div_diff[WIDTH-1:0];
                            mq  <= {mq[WIDTH-2:0], 1'b1};
                        end else begin
                            acc <= {acc[WIDTH-2:0], mq[WIDTH-1]};
                            mq  <= {mq[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc <= mul_sum[WIDTH:1];
                        mq  <= {mul_sum[0], mq[WIDTH-1:1]};
                    end
                end
                FINISH: begin
                    done     <= 1'b1;
                    div_zero <= dz_pend;
                    if (!dz_pend) begin
                        if (is_div) begin
                            hi <= rem_fix;
                            lo <= quot_fix;
                        end else begin
                            {hi, lo} <= prod_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: vector table plus divide-by-zero,
// ignored-request and asynchronous-reset sequences.
module tb_mult_div_unit;

    logic        clk, rst, start, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] op_a, op_b, wdata, hi, lo;
    logic        busy, done, div_zero;

    int n_checks = 0;
    int n_fail   = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Starts an operation from a cycle boundary (posedge+1) and follows it until done.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic we_start, input logic [31:0] wd, input int inject_at,
                          output logic [31:0] rh, output logic [31:0] rl,
                          output logic [31:0] h0, output logic [31:0] l0,
                          output int lat, output int bcnt, output logic dz,
                          output logic held, output logic overlap, output logic done0);
        logic [31:0] ph, pl;
        lat = -1; bcnt = 0; held = 1'b1; overlap = 1'b0; dz = 1'b0;
        rh = '0; rl = '0;
        start = 1'b1; op = o; op_a = a; op_b = b;
        hi_we = we_start; lo_we = we_start; wdata = wd;
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        ph = hi; pl = lo; h0 = hi; l0 = lo;
        done0 = done;
        for (int n = 0; n < 60; n++) begin
            if (n > 0) begin
                @(posedge clk); #1;
            end
            if (busy) bcnt++;
            if (busy && (hi !== ph || lo !== pl)) held = 1'b0;
            if (busy && done) overlap = 1'b1;
            if (done) begin
                lat = n; rh = hi; rl = lo; dz = div_zero;
                break;
            end
            if (n == inject_at) begin
                start = 1'b1; op = 2'b00; op_a = 32'h1; op_b = 32'h1;
                hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD;
            end else if (n == inject_at + 1) begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            end
        end
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    endtask

    logic [31:0] rh, rl, h0, l0;
    int          lat, bcnt, act_cnt;
    logic        dz, held, overlap, done0;

    initial begin
        vecs[0]  = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14};
        vecs[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[6]  = '{2'b00, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2};
        vecs[7]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[8]  = '{2'b11, 32'hFFFFFFFF, 32'd10,       32'd5,        32'h19999999};
        vecs[9]  = '{2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
        vecs[10] = '{2'b10, 32'd5,        32'd7,        32'd5,        32'd0};
        vecs[11] = '{2'b10, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002};

        rst = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'b00; op_a = '0; op_b = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset hi", 64'(hi), 64'h0);
        chk("reset lo", 64'(lo), 64'h0);
        chk("reset busy", 64'(busy), 64'h0);
        chk("reset done", 64'(done), 64'h0);
        chk("reset div_zero", 64'(div_zero), 64'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Vectors run back-to-back: each start is driven in the previous done cycle.
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 32'h0, -10,
                   rh, rl, h0, l0, lat, bcnt, dz, held, overlap, done0);
            chk($sformatf("v%0d hi", i), 64'(rh), 64'(vecs[i].eh));
            chk($sformatf("v%0d lo", i), 64'(rl), 64'(vecs[i].el));
            chk($sformatf("v%0d latency", i), 64'(lat), 64'd33);
            chk($sformatf("v%0d busy cycles", i), 64'(bcnt), 64'd33);
            chk($sformatf("v%0d div_zero", i), 64'(dz), 64'h0);
            chk($sformatf("v%0d hilo held", i), 64'(held), 64'h1);
            chk($sformatf("v%0d busy/done overlap", i), 64'(overlap), 64'h0);
            chk($sformatf("v%0d done low after start", i), 64'(done0), 64'h0);
        end
        @(posedge clk); #1;
        chk("done single pulse", 64'(done), 64'h0);

        // MTHI/MTLO preload, then divide by zero leaves HI/LO untouched.
        hi_we = 1'b1; wdata = 32'h11;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22;
        @(posedge clk); #1;
        lo_we = 1'b0;
        chk("mthi", 64'(hi), 64'h11);
        chk("mtlo", 64'(lo), 64'h22);
        run_op(2'b11, 32'd1234, 32'd0, 1'b0, 32'h0, -10,
               rh, rl, h0, l0, lat, bcnt, dz, held, overlap, done0);
        chk("divu0 latency", 64'(lat), 64'd1);
        chk("divu0 busy cycles", 64'(bcnt), 64'd1);
        chk("divu0 div_zero", 64'(dz), 64'h1);
        chk("divu0 hi", 64'(rh), 64'h11);
        chk("divu0 lo", 64'(rl), 64'h22);
        run_op(2'b10, 32'hFFFFFFF0, 32'd0, 1'b0, 32'h0, -10,
               rh, rl, h0, l0, lat, bcnt, dz, held, overlap, done0);
        chk("div0 latency", 64'(lat), 64'd1);
        chk("div0 div_zero", 64'(dz), 64'h1);
        chk("div0 hi", 64'(rh), 64'h11);
        chk("div0 lo", 64'(rl), 64'h22);
        @(posedge clk); #1;
        chk("div_zero single pulse", 64'(div_zero), 64'h0);

        // MTHI/MTLO together with start, then start/writes while busy are ignored.
        run_op(2'b01, 32'd3, 32'd4, 1'b1, 32'h5A5A, 5,
               rh, rl, h0, l0, lat, bcnt, dz, held, overlap, done0);
        chk("we with start hi", 64'(h0), 64'h5A5A);
        chk("we with start lo", 64'(l0), 64'h5A5A);
        chk("ignored hilo held", 64'(held), 64'h1);
        chk("ignored latency", 64'(lat), 64'd33);
        chk("ignored busy cycles", 64'(bcnt), 64'd33);
        chk("ignored result hi", 64'(rh), 64'h0);
        chk("ignored result lo", 64'(rl), 64'hC);
        act_cnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (busy || done) act_cnt++;
        end
        chk("no queued op", 64'(act_cnt), 64'd0);

        // Asynchronous reset in the middle of CALC, between clock edges.
        start = 1'b1; op = 2'b00; op_a = 32'd5; op_b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        chk("pre-reset busy", 64'(busy), 64'h1);
        rst = 1'b1;
        #1;
        chk("async reset hi", 64'(hi), 64'h0);
        chk("async reset lo", 64'(lo), 64'h0);
        chk("async reset busy", 64'(busy), 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        act_cnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (busy || done || hi != 0 || lo != 0) act_cnt++;
        end
        chk("aborted op silent", 64'(act_cnt), 64'd0);
        run_op(2'b11, 32'd100, 32'd7, 1'b0, 32'h0, -10,
               rh, rl, h0, l0, lat, bcnt, dz, held, overlap, done0);
        chk("post-reset divu lo", 64'(rl), 64'd14);
        chk("post-reset divu hi", 64'(rh), 64'd2);
        chk("post-reset latency", 64'(lat), 64'd33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit sitting directly downstream of the register file.
- Consumes the two register read ports (rs → op_a, rt → op_b) and implements MULT, MULTU, DIV and DIVU into dedicated HI/LO registers.
- Also accepts MTHI/MTLO writes.
- HI/LO are exposed continuously so the MFHI/MFLO path reads them combinationally.

Parameters:
- WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  operation request; sampled only in IDLE
- op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- op_a  input  WIDTH  rs value: multiplicand or dividend
- op_b  input  WIDTH  rt value: multiplier or divisor
- hi_we  input  1  MTHI write enable
- lo_we  input  1  MTLO write enable
- wdata  input  WIDTH  MTHI/MTLO data
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when HI/LO update from an operation
- div_zero  output  1  one-cycle pulse, coincident with done, for a DIV/DIVU whose divisor is 0

Behaviour:
- Reset (async, rst=1): hi=0, lo=0, busy=0, done=0, div_zero=0, state=IDLE, counter=0.
- Reset mid-operation aborts the operation; no partial result is ever written.
- Reset is fully asynchronous and is never gated by clk.

States:
- IDLE
  - start=1 at edge k: latch op, operand magnitudes (signed ops use two's-complement absolute values) and result sign flags.
  - Clear counter; go to CALC. busy=1 after edge k.
- CALC
  - One bit per cycle: shift-add for multiply, restoring shift-subtract for divide.
  - The counter increments each edge; after WIDTH edges (edge k+WIDTH) go to FINISH.
- FINISH
  - At edge k+WIDTH+1: apply sign correction, write hi/lo, done=1 for that cycle, busy=0, return to IDLE.
  - Total latency from the start edge to results visible: WIDTH+1 edges (33 for WIDTH=32).
- Divide by zero
  - Detected in IDLE at the start edge; go straight to FINISH (CALC skipped).
  - At edge k+1: done=1, div_zero=1, hi/lo unchanged.

Results:
- MULT/MULTU: {hi,lo} = full 2·WIDTH-bit product.
- DIV/DIVU: lo = quotient, hi = remainder.
- Signed divide truncates toward zero; the remainder takes the sign of the dividend.
- Signed product is negative iff the operand signs differ.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed) gives lo=0x80000000, hi=0, with no flag.

Boundary and simultaneous events:
- start while busy: ignored, with no queueing.
- hi_we/lo_we while busy: ignored.
- hi_we/lo_we while not busy: write wdata at the edge.
- hi_we/lo_we with start in IDLE: the MTHI/MTLO write takes effect at that edge; the operation result later overwrites both registers.
- done and busy are never high in the same cycle.
- Back-to-back: start may be asserted in the cycle done=1, since the state is IDLE by then.

Test Plan:
- MULT op_a=0xFFFFFFFD (-3), op_b=5 → after 33 edges: hi=0xFFFFFFFF, lo=0xFFFFFFF1, done pulses exactly once, busy high for 33 cycles.
- MULTU op_a=op_b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV op_a=0xFFFFFFF9 (-7), op_b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU op_a=100, op_b=7 → lo=14, hi=2.
- Divide-by-zero case: preload hi=0x11, lo=0x22 via MTHI/MTLO, then DIVU op_b=0 → done and div_zero both high one edge after start; hi=0x11, lo=0x22 unchanged.
- Reset and ignored-request case:
  - Mid-CALC reset: hi=lo=0 and busy=0 immediately, asynchronously and without a clock edge.
  - start and hi_we asserted during busy: no effect on state or on hi/lo.
